// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl sequencer: FSM state type,
// default count width and direction constants.
package counter_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/counter_step.sv
// WIDTH-bit count register with modulo wrap.
// Ports:
//   clk      - clock
//   clr      - synchronous active-high reset, clears q to 0
//   load     - load load_val into q (priority over en)
//   load_val - value loaded when load=1
//   en       - step q by one when set
//   dir      - 1 = increment, 0 = decrement (wraps modulo 2**WIDTH)
//   q        - registered count
module counter_step
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      // Natural WIDTH-bit overflow provides the modulo wrap in both directions.
      q <= (dir == DIR_UP) ? q + ONE : q - ONE;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a WIDTH-bit count register: loads a start value, steps it
// once per clock toward a terminal value, supports pause/abort and reports
// completion with a single-cycle done pulse.
// Ports:
//   clk      - clock
//   clr      - synchronous active-high reset, overrides all other inputs
//   start    - run request, accepted only while ready=1
//   dir      - 1 = count up, 0 = count down (captured with start)
//   load_val - initial count (captured with start)
//   term_val - terminal count (captured with start)
//   pause    - level, holds the count while running/paused
//   abort    - level, cancels a run without a done pulse
//   Q        - registered count
//   ready    - high in IDLE
//   busy     - high in RUN or PAUSED
//   done     - one-cycle completion pulse
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] term_r;
  logic             dir_r;
  logic             load;
  logic             en;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      term_r <= '0;
      dir_r  <= DIR_UP;
    end else begin
      state <= state_n;
      if (load) begin
        term_r <= term_val;
        dir_r  <= dir;
      end
    end
  end

  // Priority within a run: abort > terminal > pause > step.
  // The terminal compare is only made in RUN, so a run resumed from PAUSED
  // spends one RUN cycle before it can finish.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (Q == term_r) begin
          state_n = S_DONE;
        end else if (pause) begin
          state_n = S_PAUSED;
        end else begin
          en = 1'b1;
        end
      end
      S_PAUSED: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (!pause) begin
          state_n = S_RUN;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  counter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir_r),
    .q        (Q)
  );

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN) || (state == S_PAUSED);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: the stimulus process advances a
// behavioural model and queues the expected post-edge outputs; a monitor
// on the falling edge pops and compares, and checks the final count on
// every done pulse against a separate queue of expected completions.
module tb_counter_ctrl;

  localparam int unsigned W   = 3;
  localparam int unsigned MOD = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b1;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] term_val = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] Q;
  logic         ready;
  logic         busy;
  logic         done;

  counter_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .dir      (dir),
    .load_val (load_val),
    .term_val (term_val),
    .pause    (pause),
    .abort    (abort),
    .Q        (Q),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    bit          ready;
    bit          busy;
    bit          done;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model: a run is "active" from acceptance until it finishes
  // or is aborted; "held" marks a pause in effect; "finishing" is the
  // single reporting cycle after the count reached its target.
  bit          m_active = 1'b0;
  bit          m_held = 1'b0;
  bit          m_finishing = 1'b0;
  int unsigned m_q = 0;
  int unsigned m_target = 0;
  bit          m_up = 1'b1;

  task automatic model_edge();
    exp_t e;
    if (clr) begin
      m_active = 0; m_held = 0; m_finishing = 0;
      m_q = 0; m_target = 0; m_up = 1;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_held = 0;
        m_q = load_val; m_target = term_val; m_up = dir;
      end
    end else if (abort) begin
      m_active = 0; m_held = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (m_q == m_target) begin
      m_active = 0; m_finishing = 1;
      done_q.push_back(m_target);
    end else if (pause) begin
      m_held = 1;
    end else begin
      m_q = m_up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    end
    e.q     = m_q;
    e.ready = !m_active && !m_finishing;
    e.busy  = m_active;
    e.done  = m_finishing;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit c, input bit s, input bit d, input int unsigned lv,
                     input int unsigned tv, input bit p, input bit a);
    clr = c; start = s; dir = d; load_val = W'(lv); term_val = W'(tv);
    pause = p; abort = a;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, dir, load_val, term_val, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(Q) != int'(e.q) || ready !== e.ready || busy !== e.busy || done !== e.done) begin
        n_err++;
        $display("FAIL outputs t=%0t: Q=%0d ready=%b busy=%b done=%b, required Q=%0d ready=%b busy=%b done=%b",
                 $time, Q, ready, busy, done, e.q, e.ready, e.busy, e.done);
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected t=%0t: done=1 with no completion expected", $time);
        end else begin
          int unsigned tq;
          tq = done_q.pop_front();
          if (int'(Q) != int'(tq)) begin
            n_err++;
            $display("FAIL done_count t=%0t: Q=%0d, required %0d", $time, Q, tq);
          end
        end
      end
    end
  end

  initial begin
    // 1: reset held for two cycles while idle
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(1, 1, 0, 5, 6, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(1);

    // 2: up run 2 -> 5
    cyc(0, 1, 1, 2, 5, 0, 0);
    idle(7);

    // 3: down run 1 -> 6 across the wrap, Q retained afterwards
    cyc(0, 1, 0, 1, 6, 0, 0);
    idle(8);

    // 4: up run 0 -> 7 with a pause at Q=3; captured inputs changed mid-run
    cyc(0, 1, 1, 0, 7, 0, 0);
    cyc(0, 0, 0, 4, 1, 0, 0);
    cyc(0, 0, 0, 4, 1, 0, 0);
    cyc(0, 0, 0, 4, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 7, 1, 0);
    idle(8);

    // 5: start ignored while running, then abort while paused at Q=4
    cyc(0, 1, 1, 2, 6, 0, 0);
    cyc(0, 1, 0, 7, 0, 0, 0);
    cyc(0, 0, 1, 2, 6, 0, 0);
    cyc(0, 0, 1, 2, 6, 1, 0);
    cyc(0, 0, 1, 2, 6, 1, 0);
    cyc(0, 0, 1, 2, 6, 1, 1);
    idle(4);

    // 6: load == term finishes without stepping; clr mid-run
    cyc(0, 1, 1, 5, 5, 0, 0);
    idle(4);
    cyc(0, 1, 0, 6, 2, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(3);

    // abort on the terminal cycle wins over completion
    cyc(0, 1, 1, 3, 3, 0, 0);
    cyc(0, 0, 1, 3, 3, 0, 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
    end
    idle(12);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d cycle and %0d completion expectations left, required 0 and 0",
               exp_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
